// File: rtl/rps_pkg.sv
// Shared rock-paper-scissors codes: round results, match winner, scorer state.
// Used by the round evaluator and the match scorer.
package rps_pkg;

  typedef enum logic [1:0] {
    RES_TIE     = 2'b00,
    RES_P1      = 2'b01,
    RES_P2      = 2'b10,
    RES_INVALID = 2'b11
  } res_code_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  typedef enum logic {
    S_PLAY = 1'b0,
    S_OVER = 1'b1
  } state_t;

endpackage

// File: rtl/rps_sat_counter.sv
// 4-bit up counter with sync reset, sync clear and saturation at 15.
// Ports: clk, rst, clr, inc -> count.
module rps_sat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 4'd0;
    end else if (inc && count != 4'hF) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/rps_match_scorer.sv
// Match scorer: counts round results until a player reaches WIN_TARGET.
// Ports: clk, rst, res_valid/res_code/res_ready, clear -> scores,
// invalid_cnt, match_over, match_winner. Macro RPS_DRAW_LIMIT_EN adds
// a consecutive-tie limit (MAX_TIES) that ends the match as a draw.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int MAX_TIES   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  input  logic [1:0] res_code,
  output logic       res_ready,
  input  logic       clear,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [3:0] invalid_cnt,
  output logic       match_over,
  output logic [1:0] match_winner
);

  if (WIN_TARGET < 1 || WIN_TARGET > 15) begin : g_bad_win
    $error("WIN_TARGET out of range");
  end
  if (MAX_TIES < 1 || MAX_TIES > 15) begin : g_bad_ties
    $error("MAX_TIES out of range");
  end

  localparam logic [3:0] WIN_LAST = 4'(WIN_TARGET - 1);

  state_t  state_q, state_d;
  winner_t winner_q, winner_d;

  logic accept;
  logic is_p1, is_p2, is_tie, is_inv;
  logic p1_hit, p2_hit, tie_hit;

  assign res_ready    = (state_q == S_PLAY);
  assign match_over   = (state_q == S_OVER);
  assign match_winner = winner_q;

  // A result offered alongside clear is dropped.
  assign accept = res_valid && res_ready && !clear;

  assign is_tie = (res_code == RES_TIE);
  assign is_p1  = (res_code == RES_P1);
  assign is_p2  = (res_code == RES_P2);
  assign is_inv = (res_code == RES_INVALID);

  assign p1_hit = is_p1 && (score_p1 == WIN_LAST);
  assign p2_hit = is_p2 && (score_p2 == WIN_LAST);

  rps_sat_counter u_p1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (accept && is_p1),
    .count (score_p1)
  );

  rps_sat_counter u_p2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (accept && is_p2),
    .count (score_p2)
  );

  rps_sat_counter u_inv (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (accept && is_inv),
    .count (invalid_cnt)
  );

`ifdef RPS_DRAW_LIMIT_EN
  localparam logic [3:0] TIE_LAST = 4'(MAX_TIES - 1);

  logic [3:0] tie_cnt;

  // Streak breaks on a decisive round; invalid rounds leave it alone.
  rps_sat_counter u_tie (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear || (accept && (is_p1 || is_p2))),
    .inc   (accept && is_tie),
    .count (tie_cnt)
  );

  assign tie_hit = is_tie && (tie_cnt == TIE_LAST);
`else
  assign tie_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    if (clear) begin
      state_d  = S_PLAY;
      winner_d = WIN_NONE;
    end else if (accept) begin
      unique case (1'b1)
        p1_hit: begin
          state_d  = S_OVER;
          winner_d = WIN_P1;
        end
        p2_hit: begin
          state_d  = S_OVER;
          winner_d = WIN_P2;
        end
        tie_hit: begin
          state_d  = S_OVER;
          winner_d = WIN_NONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_PLAY;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed self-checking bench for rps_match_scorer (WIN_TARGET=3, MAX_TIES=5).
// Expectations follow RPS_DRAW_LIMIT_EN when the build defines it.
module tb_rps_match_scorer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       res_valid = 1'b0;
  logic [1:0] res_code = 2'b00;
  logic       res_ready;
  logic       clear = 1'b0;
  logic [3:0] score_p1, score_p2, invalid_cnt;
  logic       match_over;
  logic [1:0] match_winner;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rps_match_scorer #(
    .WIN_TARGET (3),
    .MAX_TIES   (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_code     (res_code),
    .res_ready    (res_ready),
    .clear        (clear),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .invalid_cnt  (invalid_cnt),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input logic [1:0] c,
                      input logic cl, input logic r);
    res_valid = v;
    res_code  = c;
    clear     = cl;
    rst       = r;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    clear     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int p1, input int p2,
                         input int inv, input int ov, input int w,
                         input int rdy);
    chk({tag, ".p1"}, int'(score_p1), p1);
    chk({tag, ".p2"}, int'(score_p2), p2);
    chk({tag, ".inv"}, int'(invalid_cnt), inv);
    chk({tag, ".over"}, int'(match_over), ov);
    chk({tag, ".win"}, int'(match_winner), w);
    chk({tag, ".rdy"}, int'(res_ready), rdy);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk_all("reset", 0, 0, 0, 0, 0, 1);

    // Idle cycle: nothing offered, nothing changes.
    step(1'b0, 2'b01, 1'b0, 1'b0);
    chk_all("idle", 0, 0, 0, 0, 0, 1);

    // P1 wins 3-1.
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("r1.p1", int'(score_p1), 1);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("r2.p2", int'(score_p2), 1);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk_all("r3", 2, 1, 0, 0, 0, 1);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk_all("win_p1", 3, 1, 0, 1, 1, 0);

    // Results in S_OVER are ignored.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10, 1'b0, 1'b0);
      chk_all("over_ign", 3, 1, 0, 1, 1, 0);
    end
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk_all("clear_over", 0, 0, 0, 0, 0, 1);

    // Invalid results saturate at 15.
    for (int i = 0; i < 15; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("inv15", int'(invalid_cnt), 15);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk_all("inv17", 0, 0, 15, 0, 0, 1);

    // Clear wins over a simultaneous result.
    step(1'b1, 2'b01, 1'b1, 1'b0);
    chk_all("clr_drop", 0, 0, 0, 0, 0, 1);

    // Tie streak: 00,00,01 then five 00.
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
    chk_all("ties4", 1, 0, 0, 0, 0, 1);
    step(1'b1, 2'b00, 1'b0, 1'b0);
`ifdef RPS_DRAW_LIMIT_EN
    chk_all("ties5", 1, 0, 0, 1, 0, 0);
`else
    chk_all("ties5", 1, 0, 0, 0, 0, 1);
`endif
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk_all("clear2", 0, 0, 0, 0, 0, 1);

    // P2 wins 3-0.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
    chk_all("win_p2", 0, 3, 0, 1, 2, 0);
    step(1'b0, 2'b00, 1'b1, 1'b0);

    // Reset mid-match, with a result and clear also offered.
    step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("p2_two", int'(score_p2), 2);
    step(1'b1, 2'b10, 1'b1, 1'b1);
    chk_all("rst_mid", 0, 0, 0, 0, 0, 1);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("after_rst", int'(score_p2), 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/rps_match_scorer.md
RPS_MATCH_SCORER -- requirements
Module: rps_match_scorer

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3, rounds a player must win to take the match (legal range 1..15).
REQ-002 SHALL have parameter MAX_TIES, default 5, consecutive-tie limit (used only under RPS_DRAW_LIMIT_EN; legal range 1..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port res_valid, input, 1, round result offered by the upstream round evaluator.
REQ-006 SHALL have port res_code, input, 2, round result: 00 tie, 01 P1 win, 10 P2 win, 11 invalid.
REQ-007 SHALL have port res_ready, output, 1, scorer can accept a round result.
REQ-008 SHALL have port clear, input, 1, single-cycle request to start a new match.
REQ-009 SHALL have port score_p1, output, 4, P1 rounds won.
REQ-010 SHALL have port score_p2, output, 4, P2 rounds won.
REQ-011 SHALL have port invalid_cnt, output, 4, invalid rounds this match, saturating.
REQ-012 SHALL have port match_over, output, 1, match decided; holds until clear.
REQ-013 SHALL have port match_winner, output, 2, 00 none/draw, 01 P1, 10 P2.

Function
REQ-014 SHALL accept a result only on a cycle with res_valid=1 and res_ready=1; the score update is visible on the next cycle.
REQ-015 SHALL implement states S_PLAY (res_ready=1) and S_OVER (res_ready=0); S_PLAY->S_OVER when an accepted result reaches the end condition; S_OVER->S_PLAY on clear.
REQ-016 SHALL drive res_ready combinationally from state only, never from res_valid.
REQ-017 SHALL on an accepted 01 increment score_p1 and on an accepted 10 increment score_p2, each by exactly 1.
REQ-018 SHALL on an accepted 11 leave both scores unchanged and increment invalid_cnt, saturating at 15.
REQ-019 SHALL on an accepted 00 leave scores unchanged.
REQ-020 SHALL enter S_OVER when the accepted result brings a score to WIN_TARGET: match_over=1 and match_winner set to that player, both on the same cycle the score becomes visible.
REQ-021 SHALL, with clear=1 in either state, zero scores, invalid_cnt, the tie streak, match_over and match_winner on the next cycle and enter S_PLAY; a result offered on that cycle is dropped, not scored.
REQ-022 SHALL ignore res_valid in S_OVER (no counter changes).
REQ-023 SHALL never let scores exceed WIN_TARGET.

Reset
REQ-024 SHALL on rst=1 enter S_PLAY with score_p1=0, score_p2=0, invalid_cnt=0, tie streak=0, match_over=0, match_winner=00, res_ready=1 on the following cycle.
REQ-025 SHALL give rst priority over clear and res_valid, including mid-match and in S_OVER.

Configuration
REQ-026 SHALL with RPS_DRAW_LIMIT_EN defined keep a consecutive-tie counter: increment on an accepted 00, zero on an accepted 01/10, unchanged on 11; on reaching MAX_TIES, enter S_OVER with match_over=1 and match_winner=00.
REQ-027 SHALL without RPS_DRAW_LIMIT_EN omit the tie counter entirely; ties never end a match.

Structure
REQ-028 SHALL take result codes (TIE, P1, P2, INVALID), winner codes and the state encoding from shared package rps_pkg, which the round evaluator also uses.
REQ-029 SHALL instantiate sub-module rps_sat_counter (4-bit, inc/clr/saturate) for score_p1, score_p2, invalid_cnt and the tie counter.

Verification
REQ-030 SHALL cover: reset, then results 01,10,01,01 (WIN_TARGET=3) -> scores 3/1, match_over=1, match_winner=01, res_ready=0.
REQ-031 SHALL cover: in S_OVER, drive res_valid=1 with code 10 for 4 cycles -> scores unchanged; then clear -> all zero and res_ready=1 next cycle.
REQ-032 SHALL cover: 17 accepted 11 results -> invalid_cnt=15, scores 0/0, match_over=0.
REQ-033 SHALL cover: clear and res_valid (code 01) on the same cycle -> score_p1=0 afterwards.
REQ-034 SHALL cover: with RPS_DRAW_LIMIT_EN, results 00,00,01, then five 00 (MAX_TIES=5) -> match_over=1, match_winner=00, score_p1=1; without the macro the same stimulus -> match_over=0.
REQ-035 SHALL cover: rst asserted in the cycle after P2 reaches 2 of 3 -> all outputs at reset values.
